// File: rtl/stump_control_seq_pkg.sv
// Shared Stump definitions: sequencer state codes and the load/store opcode.
package stump_control_seq_pkg;

   typedef enum logic [1:0] {
      STATE_FETCH   = 2'b00,
      STATE_EXECUTE = 2'b01,
      STATE_MEMORY  = 2'b10,
      STATE_ILLEGAL = 2'b11
   } state_e;

   localparam logic [2:0] OP_LDST = 3'b110;

   function automatic logic is_ldst(input logic [15:0] instr);
      return instr[15:13] == OP_LDST;
   endfunction

endpackage

// File: rtl/stump_cc_reg.sv
// Condition-code register {N,Z,V,C} with asynchronous active-low clear and write enable.
module stump_cc_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] cc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cc_reg <= 4'b0000;
      else if (en)
         cc_reg <= d;
   end

   assign q = cc_reg;

endmodule

// File: rtl/stump_control_seq.sv
// Stump sequencer: FETCH/EXECUTE/MEMORY state, instruction register, CC register
// and retired-instruction counter, paced by the memory ready handshake.
module stump_control_seq
   import stump_control_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [15:0]      mem_rdata,
   input  logic             cc_en,
   input  logic [3:0]       alu_flags,
   output logic [1:0]       state,
   output logic [15:0]      ir,
   output logic [3:0]       cc,
   output logic             mem_req,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_reg, state_next;
   logic [15:0]      ir_reg;
   logic [CNT_W-1:0] instr_count_reg;
   logic             ir_load;
   logic             retire_c;
   logic             mem_req_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= STATE_FETCH;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = STATE_FETCH;
      case (state_reg)
         STATE_FETCH:   state_next = (run && mem_ready) ? STATE_EXECUTE : STATE_FETCH;
         STATE_EXECUTE: state_next = is_ldst(ir_reg) ? STATE_MEMORY : STATE_FETCH;
         STATE_MEMORY:  state_next = mem_ready ? STATE_FETCH : STATE_MEMORY;
         STATE_ILLEGAL: state_next = STATE_FETCH;
      endcase
   end

   always_comb begin
      mem_req_c = 1'b0;
      retire_c  = 1'b0;
      ir_load   = 1'b0;
      case (state_reg)
         STATE_FETCH: begin
            mem_req_c = run;
            ir_load   = run && mem_ready;
         end
         STATE_EXECUTE: retire_c = !is_ldst(ir_reg);
         STATE_MEMORY: begin
            mem_req_c = 1'b1;
            retire_c  = mem_ready;
         end
         STATE_ILLEGAL: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ir_reg <= 16'h0000;
      else if (ir_load)
         ir_reg <= mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_count_reg <= '0;
      else if (retire_c)
         instr_count_reg <= instr_count_reg + CNT_W'(1);
   end

   // CC is only ever written while executing, so MEMORY-phase flags cannot leak in.
   stump_cc_reg u_cc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cc_en && (state_reg == STATE_EXECUTE)),
      .d     (alu_flags),
      .q     (cc)
   );

   assign state       = state_reg;
   assign ir          = ir_reg;
   assign mem_req     = rst_n && mem_req_c;
   assign retire      = retire_c;
   assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_stump_control_seq.sv
// Directed bench for stump_control_seq: per-cycle vector table plus hand-written
// sequences for asynchronous reset and counter wrap (CNT_W = 4).
module tb_stump_control_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        cc_en;
   logic [3:0]  alu_flags;
   logic [1:0]  state;
   logic [15:0] ir;
   logic [3:0]  cc;
   logic        mem_req;
   logic        retire;
   logic [3:0]  instr_count;

   int checks = 0;
   int errors = 0;

   stump_control_seq #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .cc_en       (cc_en),
      .alu_flags   (alu_flags),
      .state       (state),
      .ir          (ir),
      .cc          (cc),
      .mem_req     (mem_req),
      .retire      (retire),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic        rdy;
      logic [15:0] rdata;
      logic        cc_en;
      logic [3:0]  flags;
      logic [1:0]  e_st;
      logic [15:0] e_ir;
      logic [3:0]  e_cc;
      logic        e_req;
      logic        e_ret;
      logic [3:0]  e_cnt;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vec [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rd, input logic [15:0] d,
                        input logic ce, input logic [3:0] f);
      run = r; mem_ready = rd; mem_rdata = d; cc_en = ce; alu_flags = f;
   endtask

   initial begin
      // run rdy rdata cc_en flags | state ir cc req ret cnt
      vec[0]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 4'h0, 2'd0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'd0};
      vec[1]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 4'h0, 2'd1, 16'h1234, 4'h0, 1'b0, 1'b1, 4'd0};
      vec[2]  = '{1'b1, 1'b1, 16'hC000, 1'b1, 4'hF, 2'd0, 16'h1234, 4'h0, 1'b1, 1'b0, 4'd1};
      vec[3]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 4'h4, 2'd1, 16'hC000, 4'h0, 1'b0, 1'b0, 4'd1};
      vec[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'hF, 2'd2, 16'hC000, 4'h4, 1'b1, 1'b0, 4'd1};
      vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'hF, 2'd2, 16'hC000, 4'h4, 1'b1, 1'b0, 4'd1};
      vec[6]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 4'hF, 2'd2, 16'hC000, 4'h4, 1'b1, 1'b1, 4'd1};
      vec[7]  = '{1'b0, 1'b1, 16'h5555, 1'b1, 4'hF, 2'd0, 16'hC000, 4'h4, 1'b0, 1'b0, 4'd2};
      vec[8]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 4'h0, 2'd0, 16'hC000, 4'h4, 1'b0, 1'b0, 4'd2};
      vec[9]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 4'h0, 2'd0, 16'hC000, 4'h4, 1'b0, 1'b0, 4'd2};
      vec[10] = '{1'b0, 1'b1, 16'h5555, 1'b0, 4'h0, 2'd0, 16'hC000, 4'h4, 1'b0, 1'b0, 4'd2};
      vec[11] = '{1'b1, 1'b1, 16'h2222, 1'b0, 4'h0, 2'd0, 16'hC000, 4'h4, 1'b1, 1'b0, 4'd2};
      vec[12] = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'h9, 2'd1, 16'h2222, 4'h4, 1'b0, 1'b1, 4'd2};
      vec[13] = '{1'b1, 1'b0, 16'h3333, 1'b0, 4'h0, 2'd0, 16'h2222, 4'h4, 1'b1, 1'b0, 4'd3};
      vec[14] = '{1'b1, 1'b1, 16'h4444, 1'b0, 4'h0, 2'd0, 16'h2222, 4'h4, 1'b1, 1'b0, 4'd3};
      vec[15] = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'h0, 2'd1, 16'h4444, 4'h4, 1'b0, 1'b1, 4'd3};
      vec[16] = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'h0, 2'd0, 16'h4444, 4'h4, 1'b0, 1'b0, 4'd4};

      rst_n = 1'b0;
      drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 4'hF);
      #2;
      chk("reset_state", 32'(state), 32'h0);
      chk("reset_ir", 32'(ir), 32'h0);
      chk("reset_cc", 32'(cc), 32'h0);
      chk("reset_cnt", 32'(instr_count), 32'h0);
      chk("reset_mem_req", 32'(mem_req), 32'h0);
      chk("reset_retire", 32'(retire), 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vec[i].run, vec[i].rdy, vec[i].rdata, vec[i].cc_en, vec[i].flags);
         #1;
         $display("vec %0d: st=%0d ir=%h cc=%h req=%b ret=%b cnt=%0d",
                  i, state, ir, cc, mem_req, retire, instr_count);
         chk($sformatf("v%0d_state", i), 32'(state), 32'(vec[i].e_st));
         chk($sformatf("v%0d_ir", i), 32'(ir), 32'(vec[i].e_ir));
         chk($sformatf("v%0d_cc", i), 32'(cc), 32'(vec[i].e_cc));
         chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vec[i].e_req));
         chk($sformatf("v%0d_retire", i), 32'(retire), 32'(vec[i].e_ret));
         chk($sformatf("v%0d_cnt", i), 32'(instr_count), 32'(vec[i].e_cnt));
      end

      // Enter MEMORY on an LDST, then reset asynchronously between edges.
      @(negedge clk);
      drive(1'b1, 1'b1, 16'hC123, 1'b1, 4'hA);
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 4'hA);
      @(negedge clk);
      #1;
      chk("pre_reset_state", 32'(state), 32'h2);
      chk("pre_reset_cc", 32'(cc), 32'hA);
      #1;
      rst_n = 1'b0;
      #1;
      $display("async reset: st=%0d ir=%h cc=%h cnt=%0d req=%b", state, ir, cc, instr_count, mem_req);
      chk("async_state", 32'(state), 32'h0);
      chk("async_ir", 32'(ir), 32'h0);
      chk("async_cc", 32'(cc), 32'h0);
      chk("async_cnt", 32'(instr_count), 32'h0);
      chk("async_mem_req", 32'(mem_req), 32'h0);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h1234, 1'b0, 4'h0);
      rst_n = 1'b1;
      #1;
      chk("post_reset_req", 32'(mem_req), 32'h1);
      chk("post_reset_state", 32'(state), 32'h0);

      // 17 two-cycle instructions: counter passes 15, wraps to 0, ends at 1.
      for (int n = 0; n < 17; n++) begin
         @(negedge clk);
         #1;
         chk($sformatf("wrap%0d_exec", n), 32'(state), 32'h1);
         chk($sformatf("wrap%0d_retire", n), 32'(retire), 32'h1);
         @(negedge clk);
         #1;
         $display("wrap instr %0d: cnt=%0d", n + 1, instr_count);
         chk($sformatf("wrap%0d_cnt", n), 32'(instr_count), 32'((n + 1) % 16));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stump_control_seq.md
# stump_control_seq

Sequencing stage of the Stump control path. It holds the FETCH/EXECUTE/MEMORY state register, the instruction register (IR) and the condition-code register (CC). Together these form the `state`, `ir` and `cc` inputs consumed directly by the Stump control decoder. It waits for memory through a ready handshake, and counts and flags retired instructions.

## Interface

Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: when low, the sequencer holds in FETCH and issues no new fetch.
- `mem_ready`, input, 1: memory has completed the current access (fetch or data).
- `mem_rdata`, input, 16: instruction word returned by memory during FETCH.
- `cc_en`, input, 1: CC write enable from the decoder.
- `alu_flags`, input, 4: {N,Z,V,C} from the ALU.
- `state`, output, 2: current state; FETCH=2'b00, EXECUTE=2'b01, MEMORY=2'b10.
- `ir`, output, 16: current instruction.
- `cc`, output, 4: current {N,Z,V,C}.
- `mem_req`, output, 1: memory access requested this cycle.
- `retire`, output, 1: an instruction completes at the next edge.
- `instr_count`, output, CNT_W: retired-instruction count.

## Operation

- **FETCH:**
  - `mem_req` = `run`.
  - If `run` && `mem_ready`: `ir` <= `mem_rdata` and the next state is EXECUTE.
  - Otherwise stay in FETCH with `ir` unchanged.
- **EXECUTE:**
  - Always exactly one cycle.
  - `mem_ready` is ignored.
  - If `cc_en`: `cc` <= `alu_flags`.
  - If `ir[15:13]` == LDST (3'b110): the next state is MEMORY. Otherwise the next state is FETCH and `retire` = 1.
  - `mem_req` = 0.
- **MEMORY:**
  - `mem_req` = 1.
  - If `mem_ready`: the next state is FETCH and `retire` = 1. Otherwise stay in MEMORY.
  - `run` is ignored; an in-flight load or store always completes.
  - CC is never written in MEMORY, regardless of `cc_en`.
- **Illegal state 2'b11:** the next state is FETCH. No IR/CC/counter update, `retire` = 0, `mem_req` = 0.
- **`retire` and `instr_count`:**
  - `retire` is combinational from `state`, `ir` and `mem_ready`.
  - `instr_count` increments by 1 on each edge where `retire` = 1.
  - It wraps from 2^CNT_W−1 to 0 with no flag.
- **IR load condition:** IR is written only on a FETCH→EXECUTE transition.
- **CC write condition:** CC is written only in EXECUTE.

## Timing

- **Reset values** (immediate on `rst_n` low, independent of `clk`):
  - `state` = FETCH, `ir` = 16'h0000, `cc` = 4'b0000, `instr_count` = 0.
  - `mem_req` = 0 while `rst_n` is low.
  - `retire` = 0.
- **Reset mid-operation:** any in-flight access is abandoned. After `rst_n` rises, the first fetch request is in the first cycle.
- **Minimum cycles per instruction:**
  - Non-LDST: 2 (FETCH, EXECUTE).
  - LDST: 3 (FETCH, EXECUTE, MEMORY).
- **Wait states:** each cycle with `mem_ready` low in FETCH or MEMORY adds one cycle.
- **Outputs:**
  - `state`, `ir`, `cc` and `instr_count` are registered.
  - `mem_req` and `retire` are combinational from registered state plus `run`/`mem_ready`.
- **Update visibility:**
  - IR is visible in the EXECUTE cycle, one edge after the accepted fetch.
  - CC is visible from the cycle after EXECUTE, so a branch reads flags from the previous instruction.
- **`run` deasserted:**
  - In EXECUTE or MEMORY: the current instruction completes and the sequencer parks in FETCH.
  - In FETCH at the same edge as `mem_ready`: no IR load.

## Structure

- State codes (FETCH/EXECUTE/MEMORY) and the LDST opcode come from the shared Stump definitions include. No local redefinition.
- Add a `STATE_ILLEGAL` (2'b11) constant to the same shared file.
- One natural sub-module: `stump_cc_reg`, a 4-bit register with asynchronous active-low clear and an enable. Its enable is `cc_en` && (`state` == EXECUTE).
- State register, IR and counter stay in the top module.

## Test plan

1. **Reset and single ADD:** `rst_n` low, then high; `run` = 1; `mem_ready` = 1; `mem_rdata` = 16'h1234. The state sequence must be FETCH, EXECUTE, FETCH. `ir` = 16'h1234 in EXECUTE, `retire` = 1 in EXECUTE, and `instr_count` = 1 afterwards.
2. **LDST with waits:** `mem_rdata` = 16'hC000 (opcode 110), `mem_ready` low for 2 cycles in MEMORY. MEMORY must last 3 cycles, `retire` only in the last of them, and the total instruction time is 5 cycles.
3. **CC update:**
   - EXECUTE with `cc_en` = 1, `alu_flags` = 4'b0100 → `cc` = 4'b0100 next cycle.
   - `cc_en` = 1 during FETCH or MEMORY with `alu_flags` = 4'b1111 → `cc` unchanged.
4. **Fetch stall and run:**
   - `run` = 0 with `mem_ready` = 1 for 4 cycles → stays in FETCH, `mem_req` = 0, IR unchanged.
   - `run` = 1 → EXECUTE on the next edge.
5. **Asynchronous reset mid-MEMORY:** pulse `rst_n` low between clock edges. `state` must be 2'b00, `cc` = 0, `ir` = 0 and `instr_count` = 0 before the next edge.
6. **Counter wrap (CNT_W = 4):** run 17 non-LDST instructions → `instr_count` passes 15, then 0, and ends at 1.
